// File: rtl/alu_issue_if.sv
// Handshake bundle for the ALU issue controller: register loads, instruction
// issue, external ALU drive/return and result return. Flag ports exist only with ALU_ISSUE_FLAGS_EN.
interface alu_issue_if #(
    parameter int W    = 4,
    parameter int CW   = 2,
    parameter int CNTW = 8
);
    logic            ld_valid;
    logic            ld_ready;
    logic [1:0]      ld_addr;
    logic [W-1:0]    ld_data;
    logic            in_valid;
    logic            in_ready;
    logic [CW+7:0]   in_instr;
    logic [1:0]      alu_op;
    logic [W-1:0]    alu_in_a;
    logic [W-1:0]    alu_in_b;
    logic [CW-1:0]   alu_in_c;
    logic [W-1:0]    alu_ans;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_rd;
    logic [W-1:0]    out_data;
    logic [CNTW-1:0] instr_cnt;
`ifdef ALU_ISSUE_FLAGS_EN
    logic            out_zero;
    logic            out_neg;
`endif

    modport slave (
        input  ld_valid, ld_addr, ld_data, in_valid, in_instr,
        input  alu_ans, out_ready,
        output ld_ready, in_ready, alu_op, alu_in_a, alu_in_b, alu_in_c,
`ifdef ALU_ISSUE_FLAGS_EN
        output out_zero, out_neg,
`endif
        output out_valid, out_rd, out_data, instr_cnt
    );

    modport master (
        output ld_valid, ld_addr, ld_data, in_valid, in_instr,
        output alu_ans, out_ready,
        input  ld_ready, in_ready, alu_op, alu_in_a, alu_in_b, alu_in_c,
`ifdef ALU_ISSUE_FLAGS_EN
        input  out_zero, out_neg,
`endif
        input  out_valid, out_rd, out_data, instr_cnt
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller for an external 4-bit ALU: owns a 4-entry register
// file, runs IDLE->EXEC->RESP per instruction. Optional flags: ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl #(
    parameter int W    = 4,
    parameter int CW   = 2,
    parameter int CNTW = 8
) (
    input logic        clk,
    input logic        reset,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW+7:0]         instr_q, instr_d;
    logic [3:0][W-1:0]     rf_q, rf_d;
    logic [1:0]            out_rd_q, out_rd_d;
    logic [W-1:0]          out_data_q, out_data_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
`ifdef ALU_ISSUE_FLAGS_EN
    logic                  zero_q, zero_d;
    logic                  neg_q, neg_d;
`endif

    logic [1:0]    op_f;
    logic [CW-1:0] sh_f;
    logic [1:0]    rd_f, ra_f, rb_f;

    assign op_f = instr_q[CW+7:CW+6];
    assign sh_f = instr_q[CW+5:6];
    assign rd_f = instr_q[5:4];
    assign ra_f = instr_q[3:2];
    assign rb_f = instr_q[1:0];

    // Handshake outputs and ALU drive; ALU inputs read rf before the EXEC write.
    always_comb begin
        bus.ld_ready  = (state_q == IDLE);
        bus.in_ready  = (state_q == IDLE) && !bus.ld_valid;
        bus.out_valid = (state_q == RESP);
        bus.out_rd    = out_rd_q;
        bus.out_data  = out_data_q;
        bus.instr_cnt = cnt_q;
        bus.alu_op    = '0;
        bus.alu_in_a  = '0;
        bus.alu_in_b  = '0;
        bus.alu_in_c  = '0;
        if (state_q == EXEC) begin
            bus.alu_op   = op_f;
            bus.alu_in_a = rf_q[ra_f];
            bus.alu_in_b = rf_q[rb_f];
            bus.alu_in_c = sh_f;
        end
`ifdef ALU_ISSUE_FLAGS_EN
        bus.out_zero = zero_q;
        bus.out_neg  = neg_q;
`endif
    end

    // Next-state: loads win in IDLE, EXEC writes back, RESP waits for consumer.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rf_d       = rf_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
`ifdef ALU_ISSUE_FLAGS_EN
        zero_d     = zero_q;
        neg_d      = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.ld_valid) begin
                    rf_d[bus.ld_addr] = bus.ld_data;
                end else if (bus.in_valid) begin
                    instr_d = bus.in_instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rf_d[rd_f] = bus.alu_ans;
                out_data_d = bus.alu_ans;
                out_rd_d   = rd_f;
`ifdef ALU_ISSUE_FLAGS_EN
                zero_d     = (bus.alu_ans == '0);
                neg_d      = bus.alu_ans[W-1];
`endif
                state_d    = RESP;
            end
            RESP: begin
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            rf_q       <= '0;
            out_rd_q   <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rf_q       <= rf_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
`ifdef ALU_ISSUE_FLAGS_EN
            zero_q     <= zero_d;
            neg_q      <= neg_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl with a behavioural ALU
// and a register-file/counter reference model.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rf_m[4];
    int   cnt_m;
    int   last_data;

    always #5 clk = ~clk;

    alu_issue_if #(.W(4), .CW(2), .CNTW(8)) bus ();

    alu_issue_ctrl #(.W(4), .CW(2), .CNTW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic int alu_ref(input int op, input int a, input int b, input int sh);
        int s;
        case (op)
            0: begin
                s = (a >= 8) ? a - 16 : a;
                return (s >>> sh) & 15;
            end
            1: return (a >> sh) & 15;
            2: return (a - b + 16) % 16;
            default: return (a + b) % 16;
        endcase
    endfunction

    assign bus.alu_ans = 4'(alu_ref(int'(bus.alu_op), int'(bus.alu_in_a),
                                    int'(bus.alu_in_b), int'(bus.alu_in_c)));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (rf_m[i]) rf_m[i] = 0;
        cnt_m = 0;
    endtask

    task automatic ld(input int a, input int d);
        int k = 0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 2'(a);
        bus.ld_data  = 4'(d);
        #1;
        while (!bus.ld_ready && k < 20) begin
            tick();
            k++;
        end
        chk("ld_ready", int'(bus.ld_ready), 1);
        tick();
        bus.ld_valid = 1'b0;
        rf_m[a] = d;
    endtask

    task automatic issue(input int op, input int sh, input int rd,
                         input int ra, input int rb, input int hold);
        int k = 0;
        int exp;
        #1;
        while (!bus.in_ready && k < 20) begin
            tick();
            k++;
        end
        chk("in_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_instr = {2'(op), 2'(sh), 2'(rd), 2'(ra), 2'(rb)};
        exp = alu_ref(op, rf_m[ra], rf_m[rb], sh);
        tick();
        bus.in_valid = 1'b0;
        bus.in_instr = 10'($urandom);
        chk("exec_ov", int'(bus.out_valid), 0);
        chk("alu_op", int'(bus.alu_op), op);
        chk("alu_in_a", int'(bus.alu_in_a), rf_m[ra]);
        chk("alu_in_b", int'(bus.alu_in_b), rf_m[rb]);
        chk("alu_in_c", int'(bus.alu_in_c), sh);
        rf_m[rd] = exp;
        tick();
        chk("resp_in_a", int'(bus.alu_in_a), 0);
`ifdef ALU_ISSUE_FLAGS_EN
        chk("zero", int'(bus.out_zero), (exp == 0) ? 1 : 0);
        chk("neg", int'(bus.out_neg), (exp >= 8) ? 1 : 0);
`endif
        for (int i = 0; i <= hold; i++) begin
            chk("out_valid", int'(bus.out_valid), 1);
            chk("out_data", int'(bus.out_data), exp);
            chk("out_rd", int'(bus.out_rd), rd);
            if (i < hold) begin
                bus.ld_valid = 1'b1;
                bus.ld_addr  = 2'($urandom);
                bus.ld_data  = 4'($urandom);
                #1;
                chk("resp_in_ready", int'(bus.in_ready), 0);
                chk("resp_ld_ready", int'(bus.ld_ready), 0);
                tick();
                bus.ld_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        cnt_m = (cnt_m + 1) % 256;
        chk("done_ov", int'(bus.out_valid), 0);
        chk("done_in_ready", int'(bus.in_ready), 1);
        chk("instr_cnt", int'(bus.instr_cnt), cnt_m);
        last_data = exp;
    endtask

    initial begin
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_ov", int'(bus.out_valid), 0);
        chk("rst_cnt", int'(bus.instr_cnt), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_rd", int'(bus.out_rd), 0);
        chk("rst_alu_a", int'(bus.alu_in_a), 0);

        ld(1, 5); ld(2, 3);
        issue(3, 0, 0, 1, 2, 0);
        chk("t1_add", last_data, 8);
        issue(3, 0, 1, 0, 0, 0);
        chk("t1_rf0", last_data, 0);

        ld(1, 3); ld(2, 5);
        issue(2, 0, 3, 1, 2, 0);
        chk("t2_sub", last_data, 14);

        ld(1, 8);
        issue(0, 2, 2, 1, 0, 0);
        chk("t3_sra", last_data, 14);
        issue(1, 2, 2, 1, 0, 0);
        chk("t3_srl", last_data, 2);

        ld(3, 6);
        issue(3, 0, 0, 3, 3, 5);

        bus.ld_valid = 1'b1; bus.ld_addr = 2'd2; bus.ld_data = 4'd9;
        bus.in_valid = 1'b1; bus.in_instr = {2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
        #1;
        chk("t5_in_ready", int'(bus.in_ready), 0);
        chk("t5_ld_ready", int'(bus.ld_ready), 1);
        tick();
        bus.ld_valid = 1'b0;
        bus.in_valid = 1'b0;
        rf_m[2] = 9;
        issue(3, 0, 1, 2, 2, 0);
        chk("t5_new", last_data, 2);

        bus.in_valid = 1'b1;
        bus.in_instr = {2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            chk("t6_ov", int'(bus.out_valid), 0);
            chk("t6_cnt", int'(bus.instr_cnt), 0);
            tick();
        end
        for (int r = 0; r < 4; r++) issue(3, 0, r, r, r, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 256; n++) begin
            if ($urandom_range(0, 3) == 0)
                ld(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        chk("wrap", int'(bus.instr_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
